// File: rtl/rs232_rx_cfg.sv
// rs232_rx_cfg - configurable asynchronous serial receiver.
//
// Each frame is a start bit, DATA_W data bits sent LSB first, an optional
// parity bit, and STOP_BITS stop bits. Every bit is sampled once, at its
// mid-point, on a CLK_DIV-cycle bit grid. The grid is aligned to the falling
// edge of the synchronised line.
//
// Ports
//   clk_i       clock; all state updates on its rising edge
//   rst_i       asynchronous, active-high reset
//   rx_i        asynchronous serial line (idles high)
//   par_mode_i  parity mode: 00 none, 01 even, 10 odd, 11 none
//   dout_o      data word of the last completed frame
//   valid_o     one-cycle pulse when a frame completes
//   perr_o      parity error of the last completed frame
//   ferr_o      framing error (a stop bit sampled low) of the last frame
//   busy_o      high while the receiver is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a falling edge of the synchronised line
// START  | timing to the mid-point of the start bit (false-start check)
// DATA   | sampling DATA_W data bits into the shift register
// PARITY | sampling the parity bit (only when parity is enabled)
// STOP   | sampling the stop bit(s); the final sample completes the frame
module rs232_rx_cfg #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic [1:0]        par_mode_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic              perr_o,
  output logic              ferr_o,
  output logic              busy_o
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_W);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                sync_meta_q, rxs_q, rxs_prev_q;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [1:0]          mode_q, mode_d;
  logic                perr_acc_q, perr_acc_d;
  logic                ferr_acc_q, ferr_acc_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                tick;
  logic                par_en;

  // Two-flop synchroniser plus one history flop for edge detection. All three
  // reset to the idle level, so a start needs a genuine high-to-low change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_q <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
    end else begin
      sync_meta_q <= rx_i;
      rxs_q       <= sync_meta_q;
      rxs_prev_q  <= rxs_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      mode_q     <= 2'b00;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      mode_q     <= mode_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // The timer counts down to zero; zero marks the sample cycle of the current bit.
  assign tick   = (timer_q == '0);
  // Parity is active only for modes 01 and 10. mode_q[1] selects odd parity.
  assign par_en = ^mode_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d    = S_START;
          timer_d    = HALF_M1;
          cnt_d      = '0;
          mode_d     = par_mode_i;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end

      S_START: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else if (rxs_q) begin
          // The line is high again at mid-bit, so this was a glitch. Drop it
          // without touching the outputs.
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          timer_d = FULL_M1;
        end
      end

      S_DATA: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shreg_d = {rxs_q, shreg_q[DATA_W-1:1]};
          timer_d = FULL_M1;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else begin
          // The error is (data ^ parity bit) for even parity, inverted for odd.
          perr_acc_d = (^shreg_q) ^ rxs_q ^ mode_q[1];
          timer_d    = FULL_M1;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else if (cnt_q == LAST_STOP) begin
          // Return to IDLE at mid-stop, so the next start edge can be caught
          // right away.
          state_d = S_IDLE;
          timer_d = '0;
          cnt_d   = '0;
          dout_d  = shreg_q;
          perr_d  = perr_acc_q;
          ferr_d  = ferr_acc_q | ~rxs_q;
          valid_d = 1'b1;
        end else begin
          ferr_acc_d = ferr_acc_q | ~rxs_q;
          cnt_d      = cnt_q + 1'b1;
          timer_d    = FULL_M1;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign perr_o  = perr_q;
  assign ferr_o  = ferr_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_rx_cfg.sv
// Directed testbench for rs232_rx_cfg. It uses two instances:
//   u_dut1 : DATA_W=8, CLK_DIV=16, STOP_BITS=1
//   u_dut2 : DATA_W=7, CLK_DIV=16, STOP_BITS=2
module tb_rs232_rx_cfg;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [1:0] mode1 = 2'b00;
  logic [1:0] mode2 = 2'b01;
  logic [7:0] dout1;
  logic [6:0] dout2;
  logic       valid1, perr1, ferr1, busy1;
  logic       valid2, perr2, ferr2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt1 = 0;
  int vcnt2 = 0;
  int vt_last = 0;
  int vt_prev = 0;

  rs232_rx_cfg #(.DATA_W(8), .CLK_DIV(16), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx1), .par_mode_i(mode1),
    .dout_o(dout1), .valid_o(valid1), .perr_o(perr1), .ferr_o(ferr1), .busy_o(busy1)
  );

  rs232_rx_cfg #(.DATA_W(7), .CLK_DIV(16), .STOP_BITS(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx2), .par_mode_i(mode2),
    .dout_o(dout2), .valid_o(valid2), .perr_o(perr2), .ferr_o(ferr2), .busy_o(busy2)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Count every cycle valid_o is high. A pulse that lasts longer than one
  // cycle therefore shows up as an extra count.
  always @(negedge clk_i) begin
    if (valid1) begin
      vcnt1 = vcnt1 + 1;
      vt_prev = vt_last;
      vt_last = cyc;
    end
    if (valid2) vcnt2 = vcnt2 + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 1) rx1 = v;
    else rx2 = v;
    wait_cycles(16);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input logic use_par, input logic par_bit,
                            input int nstop, input logic [1:0] stopv,
                            input logic chg_mode, input logic [1:0] new_mode);
    drive_bit(which, 1'b0);
    if (chg_mode) begin
      if (which == 1) mode1 = new_mode;
      else mode2 = new_mode;
    end
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (use_par) drive_bit(which, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(which, stopv[i]);
    if (which == 1) rx1 = 1'b1;
    else rx2 = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wait_cycles(3);
    checks++;
    if ({dout1, valid1, perr1, ferr1, busy1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut1: got dout=%h v=%b p=%b f=%b b=%b, want all 0", dout1, valid1, perr1, ferr1, busy1);
    end
    checks++;
    if ({dout2, valid2, perr2, ferr2, busy2} !== 11'h000) begin
      errors++;
      $display("FAIL reset_dut2: got dout=%h v=%b p=%b f=%b b=%b, want all 0", dout2, valid2, perr2, ferr2, busy2);
    end
    rst_i = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_even_parity();
    int v0;
    v0 = vcnt1;
    mode1 = 2'b01;
    send_frame(1, 9'h0A5, 8, 1'b1, 1'b0, 1, 2'b01, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if (vcnt1 - v0 !== 1) begin
      errors++;
      $display("FAIL even_valid_count: got %0d, want 1", vcnt1 - v0);
    end
    checks++;
    if ({dout1, perr1, ferr1, busy1} !== {8'hA5, 3'b000}) begin
      errors++;
      $display("FAIL even_result: got dout=%h p=%b f=%b b=%b, want a5 0 0 0", dout1, perr1, ferr1, busy1);
    end
  endtask

  task automatic test_odd_parity();
    int v0;
    v0 = vcnt1;
    mode1 = 2'b10;
    // Mode changes after the start edge must not affect the frame in flight.
    send_frame(1, 9'h0A5, 8, 1'b1, 1'b0, 1, 2'b01, 1'b1, 2'b01);
    wait_cycles(20);
    checks++;
    if (vcnt1 - v0 !== 1) begin
      errors++;
      $display("FAIL odd_valid_count: got %0d, want 1", vcnt1 - v0);
    end
    checks++;
    if ({dout1, perr1, ferr1} !== {8'hA5, 2'b10}) begin
      errors++;
      $display("FAIL odd_result: got dout=%h p=%b f=%b, want a5 1 0", dout1, perr1, ferr1);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vcnt1;
    rx1 = 1'b0;
    wait_cycles(4);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high: got %b, want 1", busy1);
    end
    rx1 = 1'b1;
    wait_cycles(30);
    checks++;
    if (vcnt1 - v0 !== 0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_frame: got pulses=%0d busy=%b, want 0 0", vcnt1 - v0, busy1);
    end
    checks++;
    if ({dout1, perr1, ferr1} !== {8'hA5, 2'b10}) begin
      errors++;
      $display("FAIL glitch_flags_held: got dout=%h p=%b f=%b, want a5 1 0", dout1, perr1, ferr1);
    end
  endtask

  task automatic test_framing();
    mode1 = 2'b00;
    send_frame(1, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b00, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if ({dout1, perr1, ferr1} !== {8'h3C, 2'b01}) begin
      errors++;
      $display("FAIL framing_result: got dout=%h p=%b f=%b, want 3c 0 1", dout1, perr1, ferr1);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcnt1;
    mode1 = 2'b00;
    send_frame(1, 9'h001, 8, 1'b0, 1'b0, 1, 2'b01, 1'b0, 2'b00);
    send_frame(1, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b01, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if (vcnt1 - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d, want 2", vcnt1 - v0);
    end
    checks++;
    if (vt_last - vt_prev !== 160) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d, want 160", vt_last - vt_prev);
    end
    checks++;
    if ({dout1, perr1, ferr1} !== {8'hFF, 2'b00}) begin
      errors++;
      $display("FAIL b2b_result: got dout=%h p=%b f=%b, want ff 0 0", dout1, perr1, ferr1);
    end
  endtask

  task automatic test_variant();
    int v0;
    v0 = vcnt2;
    mode2 = 2'b01;
    send_frame(2, 9'h07F, 7, 1'b1, 1'b1, 2, 2'b11, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if (vcnt2 - v0 !== 1) begin
      errors++;
      $display("FAIL var_valid_count: got %0d, want 1", vcnt2 - v0);
    end
    checks++;
    if ({dout2, perr2, ferr2} !== {7'h7F, 2'b00}) begin
      errors++;
      $display("FAIL var_result: got dout=%h p=%b f=%b, want 7f 0 0", dout2, perr2, ferr2);
    end
    // The first stop bit is good and the second is low. Both are checked.
    send_frame(2, 9'h07F, 7, 1'b1, 1'b1, 2, 2'b01, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if ({vcnt2 - v0, ferr2, perr2} !== {32'd2, 2'b10}) begin
      errors++;
      $display("FAIL var_stop2_ferr: got pulses=%0d f=%b p=%b, want 2 1 0", vcnt2 - v0, ferr2, perr2);
    end
  endtask

  task automatic test_break();
    int v0;
    v0 = vcnt1;
    mode1 = 2'b00;
    rx1 = 1'b0;
    wait_cycles(240);
    checks++;
    if ({vcnt1 - v0, dout1, perr1, ferr1} !== {32'd1, 8'h00, 2'b01}) begin
      errors++;
      $display("FAIL break_frame: got pulses=%0d dout=%h p=%b f=%b, want 1 00 0 1", vcnt1 - v0, dout1, perr1, ferr1);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL break_idle: got busy=%b, want 0", busy1);
    end
    rx1 = 1'b1;
    wait_cycles(20);
    checks++;
    if (vcnt1 - v0 !== 1) begin
      errors++;
      $display("FAIL break_no_restart: got pulses=%0d, want 1", vcnt1 - v0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    mode1 = 2'b01;
    rx1 = 1'b0;
    wait_cycles(16);
    drive_bit(1, 1'b0);
    drive_bit(1, 1'b1);
    drive_bit(1, 1'b0);
    rx1 = 1'b1;
    wait_cycles(8);
    v0 = vcnt1;
    rst_i = 1'b1;
    wait_cycles(3);
    checks++;
    if ({dout1, valid1, perr1, ferr1, busy1} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs: got dout=%h v=%b p=%b f=%b b=%b, want all 0", dout1, valid1, perr1, ferr1, busy1);
    end
    rst_i = 1'b0;
    wait_cycles(200);
    checks++;
    if (vcnt1 - v0 !== 0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_valid: got pulses=%0d busy=%b, want 0 0", vcnt1 - v0, busy1);
    end
    send_frame(1, 9'h05A, 8, 1'b1, 1'b0, 1, 2'b01, 1'b0, 2'b00);
    wait_cycles(20);
    checks++;
    if ({vcnt1 - v0, dout1, perr1, ferr1} !== {32'd1, 8'h5A, 2'b00}) begin
      errors++;
      $display("FAIL midreset_next_frame: got pulses=%0d dout=%h p=%b f=%b, want 1 5a 0 0", vcnt1 - v0, dout1, perr1, ferr1);
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_variant();
    test_break();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
